// File: rtl/adder_drv_pkg.sv
// Shared types and helpers for the adder operand driver.
//   state_t      : run FSM states
//   DEFAULT_TAPS : x^32+x^22+x^2+x+1 Galois feedback mask
//   lfsr_next    : one Galois LFSR step, computed on a 64-bit container
package adder_drv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;

  // Widest LFSR the helper supports; callers zero-extend into it.
  localparam int unsigned LFSR_MAX_WIDTH = 64;

  // Galois step: shift right, fold the taps in when the lsb falls out.
  function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_next(
    input logic [LFSR_MAX_WIDTH-1:0] s,
    input logic [LFSR_MAX_WIDTH-1:0] taps
  );
    return (s >> 1) ^ (s[0] ? taps : LFSR_MAX_WIDTH'(0));
  endfunction

endpackage

// File: rtl/adder_operand_driver_lfsr.sv
// Galois LFSR operand source (WIDTH <= 64).
//   clk, rst : clock, async active-high reset (reloads seed)
//   load     : reload seed
//   step     : advance one step
//   value    : current LFSR state
module galois_lfsr
  import adder_drv_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] value
);

  // An all-zero state would lock up the LFSR.
  localparam logic [WIDTH-1:0] SEED_FIX = (SEED == '0) ? WIDTH'(1) : SEED;

  // State register; load has priority over step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= SEED_FIX;
    end else if (load) begin
      value <= SEED_FIX;
    end else if (step) begin
      value <= WIDTH'(lfsr_next(LFSR_MAX_WIDTH'(value), LFSR_MAX_WIDTH'(TAPS)));
    end
  end

endmodule

// File: rtl/adder_operand_driver.sv
// Synthesizable stimulus/checker for the two-handshake adder wrapper.
// Generates operand pairs, offers them on in_valid/in_ready, accepts the
// result on res_valid/res_ready, and keeps pass/fail statistics.
//   clk, rst        : clock, async active-high reset
//   start           : begin a run (honoured only in IDLE/DONE)
//   mode            : 0 = LFSR operands, 1 = directed (index, ~index)
//   num_txn         : transactions per run
//   a, b, in_valid  : operand channel out, in_ready back
//   res_data/valid  : result channel in, res_ready back
//   busy, done      : run status
//   txn_count       : results accepted
//   err_count       : mismatches (saturating)
//   first_err_idx   : index of first mismatch, FFFF if none
module adder_operand_driver
  import adder_drv_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      RES_WIDTH = WIDTH + 1,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0] SEED_A    = WIDTH'(32'h0000_0001),
  parameter logic [WIDTH-1:0] SEED_B    = WIDTH'(32'h0000_0002)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [15:0]          num_txn,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic                 in_valid,
  input  logic                 in_ready,
  input  logic [RES_WIDTH-1:0] res_data,
  input  logic                 res_valid,
  output logic                 res_ready,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          txn_count,
  output logic [15:0]          err_count,
  output logic [15:0]          first_err_idx
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] NO_ERR = 16'hFFFF;

  // Operand registers are loaded together with the LFSRs, so the seeds are
  // needed here directly (zero seed replaced by 1, as in the LFSR).
  localparam logic [WIDTH-1:0] SEED_A_FIX = (SEED_A == '0) ? WIDTH'(1) : SEED_A;
  localparam logic [WIDTH-1:0] SEED_B_FIX = (SEED_B == '0) ? WIDTH'(1) : SEED_B;

  state_t               state, state_nxt;
  logic                 mode_q, mode_nxt;
  logic [CNT_W-1:0]     num_q, num_nxt;
  logic [CNT_W-1:0]     txn_nxt, err_nxt, fei_nxt;
  logic [RES_WIDTH-1:0] expected, exp_nxt;
  logic [WIDTH-1:0]     a_nxt, b_nxt;
  logic                 in_valid_nxt, res_ready_nxt, busy_nxt, done_nxt;
  logic                 lfsr_load, lfsr_step;
  logic [WIDTH-1:0]     lfsr_a, lfsr_b;
  logic [WIDTH-1:0]     lfsr_a_adv, lfsr_b_adv;
  logic [WIDTH:0]       op_sum;
  logic [CNT_W-1:0]     txn_inc;

  galois_lfsr #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED_A)) u_lfsr_a (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .value (lfsr_a)
  );

  galois_lfsr #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED_B)) u_lfsr_b (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .value (lfsr_b)
  );

  // Values the LFSRs will hold after this cycle's step; these become the
  // operands of the next transaction.
  assign lfsr_a_adv = WIDTH'(lfsr_next(LFSR_MAX_WIDTH'(lfsr_a), LFSR_MAX_WIDTH'(TAPS)));
  assign lfsr_b_adv = WIDTH'(lfsr_next(LFSR_MAX_WIDTH'(lfsr_b), LFSR_MAX_WIDTH'(TAPS)));
  assign op_sum     = {1'b0, a} + {1'b0, b};
  assign txn_inc    = txn_count + CNT_W'(1);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mode_q        <= 1'b0;
      num_q         <= '0;
      txn_count     <= '0;
      err_count     <= '0;
      first_err_idx <= NO_ERR;
      expected      <= '0;
      a             <= '0;
      b             <= '0;
      in_valid      <= 1'b0;
      res_ready     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      mode_q        <= mode_nxt;
      num_q         <= num_nxt;
      txn_count     <= txn_nxt;
      err_count     <= err_nxt;
      first_err_idx <= fei_nxt;
      expected      <= exp_nxt;
      a             <= a_nxt;
      b             <= b_nxt;
      in_valid      <= in_valid_nxt;
      res_ready     <= res_ready_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    mode_nxt      = mode_q;
    num_nxt       = num_q;
    txn_nxt       = txn_count;
    err_nxt       = err_count;
    fei_nxt       = first_err_idx;
    exp_nxt       = expected;
    a_nxt         = a;
    b_nxt         = b;
    in_valid_nxt  = in_valid;
    res_ready_nxt = res_ready;
    busy_nxt      = busy;
    done_nxt      = done;
    lfsr_load     = 1'b0;
    lfsr_step     = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          mode_nxt  = mode;
          num_nxt   = num_txn;
          txn_nxt   = '0;
          err_nxt   = '0;
          fei_nxt   = NO_ERR;
          lfsr_load = 1'b1;
          if (num_txn == '0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt    = SEND;
            in_valid_nxt = 1'b1;
            busy_nxt     = 1'b1;
            done_nxt     = 1'b0;
            a_nxt        = mode ? '0 : SEED_A_FIX;
            b_nxt        = mode ? '1 : SEED_B_FIX;
          end
        end
      end

      SEND: begin
        if (in_valid && in_ready) begin
          state_nxt     = RECV;
          in_valid_nxt  = 1'b0;
          res_ready_nxt = 1'b1;
          exp_nxt       = RES_WIDTH'(op_sum);
        end
      end

      RECV: begin
        if (res_valid && res_ready) begin
          res_ready_nxt = 1'b0;
          lfsr_step     = 1'b1;
          txn_nxt       = txn_inc;
          if (res_data != expected) begin
            if (err_count != NO_ERR) begin
              err_nxt = err_count + CNT_W'(1);
            end
            // err_count is zero only before the first mismatch of the run.
            if (err_count == '0) begin
              fei_nxt = txn_count;
            end
          end
          if (txn_inc == num_q) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt    = SEND;
            in_valid_nxt = 1'b1;
            a_nxt        = mode_q ? WIDTH'(txn_inc) : lfsr_a_adv;
            b_nxt        = mode_q ? ~WIDTH'(txn_inc) : lfsr_b_adv;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_adder_operand_driver.sv
// Directed bench for adder_operand_driver; the bench plays the adder.
module tb_adder_operand_driver;

  localparam int W  = 32;
  localparam int RW = 33;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [15:0]   num_txn;
  logic [W-1:0]  a, b;
  logic          in_valid, in_ready;
  logic [RW-1:0] res_data;
  logic          res_valid, res_ready;
  logic          busy, done;
  logic [15:0]   txn_count, err_count, first_err_idx;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  adder_operand_driver dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mode          (mode),
    .num_txn       (num_txn),
    .a             (a),
    .b             (b),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .res_data      (res_data),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .busy          (busy),
    .done          (done),
    .txn_count     (txn_count),
    .err_count     (err_count),
    .first_err_idx (first_err_idx)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the next negedge.
  task automatic do_start(input logic m, input logic [15:0] n);
    start = 1'b1; mode = m; num_txn = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Adder stand-in: accept operands, return their sum plus inj.
  task automatic run_txn(input int inj, output logic [W-1:0] oa, output logic [W-1:0] ob,
                         output bit ok);
    int n;
    ok = 1'b1; oa = '0; ob = '0;
    in_ready = 1'b1;
    n = 0;
    while (in_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_valid !== 1'b1) begin
      ok = 1'b0; in_ready = 1'b0;
      return;
    end
    oa = a; ob = b;
    @(negedge clk);
    in_ready = 1'b0;
    if (res_ready !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    res_data  = ({1'b0, oa} + {1'b0, ob}) + RW'(inj);
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; num_txn = '0;
    in_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    #1;
    total++;
    if ({a, b} !== '0) $display("FAIL reset_ab: got a=%h b=%h want 0", a, b); else passed++;
    total++;
    if ({in_valid, res_ready, busy, done} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {in_valid, res_ready, busy, done});
    else passed++;
    total++;
    if ({txn_count, err_count, first_err_idx} !== {16'd0, 16'd0, 16'hFFFF})
      $display("FAIL reset_counts: got %h %h %h want 0 0 ffff", txn_count, err_count, first_err_idx);
    else passed++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] oa, ob;
    bit ok;
    do_start(1'b1, 16'd4);
    for (int i = 0; i < 4; i++) begin
      run_txn(0, oa, ob, ok);
      total++;
      if (!ok || oa !== W'(i) || ob !== ~W'(i))
        $display("FAIL directed_op%0d: got ok=%0d a=%h b=%h want a=%h b=%h", i, ok, oa, ob, W'(i), ~W'(i));
      else passed++;
    end
    total++;
    if ({done, busy, txn_count, err_count, first_err_idx} !== {1'b1, 1'b0, 16'd4, 16'd0, 16'hFFFF})
      $display("FAIL directed_end: got done=%b busy=%b txn=%0d err=%0d fei=%h want 1 0 4 0 ffff",
               done, busy, txn_count, err_count, first_err_idx);
    else passed++;
  endtask

  task automatic test_lfsr();
    logic [W-1:0] oa, ob;
    bit ok;
    do_start(1'b0, 16'd2);
    run_txn(0, oa, ob, ok);
    total++;
    if (!ok || oa !== 32'h0000_0001 || ob !== 32'h0000_0002)
      $display("FAIL lfsr_txn0: got ok=%0d a=%h b=%h want 00000001 00000002", ok, oa, ob);
    else passed++;
    run_txn(0, oa, ob, ok);
    total++;
    if (!ok || oa !== 32'h8020_0003 || ob !== 32'h0000_0001)
      $display("FAIL lfsr_txn1: got ok=%0d a=%h b=%h want 80200003 00000001", ok, oa, ob);
    else passed++;
    total++;
    if ({done, txn_count, err_count} !== {1'b1, 16'd2, 16'd0})
      $display("FAIL lfsr_end: got done=%b txn=%0d err=%0d want 1 2 0", done, txn_count, err_count);
    else passed++;
  endtask

  task automatic test_backpressure();
    do_start(1'b1, 16'd1);
    // A stray result during SEND must not be consumed.
    res_valid = 1'b1; res_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({in_valid, res_ready, a, b, txn_count} !== {1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 16'd0})
        $display("FAIL bp_send%0d: got iv=%b rr=%b a=%h b=%h txn=%0d want 1 0 0 ffffffff 0",
                 i, in_valid, res_ready, a, b, txn_count);
      else passed++;
    end
    res_valid = 1'b0;
    in_ready  = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
    total++;
    if ({in_valid, res_ready} !== 2'b01)
      $display("FAIL bp_accept: got iv=%b rr=%b want 0 1", in_valid, res_ready);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({res_ready, a, b, txn_count} !== {1'b1, 32'h0, 32'hFFFF_FFFF, 16'd0})
        $display("FAIL bp_recv%0d: got rr=%b a=%h b=%h txn=%0d want 1 0 ffffffff 0",
                 i, res_ready, a, b, txn_count);
      else passed++;
    end
    res_data = 33'h0_FFFF_FFFF; res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    total++;
    if ({done, res_ready, txn_count, err_count} !== {1'b1, 1'b0, 16'd1, 16'd0})
      $display("FAIL bp_end: got done=%b rr=%b txn=%0d err=%0d want 1 0 1 0",
               done, res_ready, txn_count, err_count);
    else passed++;
  endtask

  task automatic test_error_inject();
    logic [W-1:0] oa, ob;
    bit ok;
    bit all_ok;
    all_ok = 1'b1;
    do_start(1'b1, 16'd4);
    for (int i = 0; i < 4; i++) begin
      run_txn((i == 2) ? 1 : 0, oa, ob, ok);
      all_ok &= ok;
    end
    total++;
    if (!all_ok || {err_count, first_err_idx, txn_count} !== {16'd1, 16'd2, 16'd4})
      $display("FAIL err_inject: got ok=%0d err=%0d fei=%h txn=%0d want 1 0002 4",
               all_ok, err_count, first_err_idx, txn_count);
    else passed++;
  endtask

  task automatic test_zero_and_busy_start();
    logic [W-1:0] oa, ob;
    logic [W-1:0] first_b;
    bit ok;
    bit all_ok;
    do_start(1'b1, 16'd0);
    total++;
    if ({done, in_valid, busy} !== 3'b100)
      $display("FAIL zero_done: got done=%b iv=%b busy=%b want 1 0 0", done, in_valid, busy);
    else passed++;
    all_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (in_valid !== 1'b0 || done !== 1'b1) all_ok = 1'b0;
    end
    total++;
    if (!all_ok) $display("FAIL zero_idle: got iv=%b done=%b want 0 1", in_valid, done);
    else passed++;
    do_start(1'b1, 16'd3);
    do_start(1'b0, 16'd0);
    total++;
    if ({busy, done, in_valid, a} !== {1'b1, 1'b0, 1'b1, 32'h0})
      $display("FAIL busy_start: got busy=%b done=%b iv=%b a=%h want 1 0 1 0", busy, done, in_valid, a);
    else passed++;
    all_ok = 1'b1;
    first_b = '0;
    for (int i = 0; i < 3; i++) begin
      run_txn(0, oa, ob, ok);
      all_ok &= ok;
      if (i == 0) first_b = ob;
    end
    total++;
    if (!all_ok || {done, txn_count, first_b} !== {1'b1, 16'd3, 32'hFFFF_FFFF})
      $display("FAIL busy_run: got ok=%0d done=%b txn=%0d b0=%h want 1 3 ffffffff",
               all_ok, done, txn_count, first_b);
    else passed++;
  endtask

  task automatic test_rst_mid();
    logic [W-1:0] oa, ob;
    bit ok;
    do_start(1'b0, 16'd3);
    run_txn(0, oa, ob, ok);
    total++;
    if (!ok || txn_count !== 16'd1)
      $display("FAIL rstmid_pre: got ok=%0d txn=%0d want 1 1", ok, txn_count);
    else passed++;
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
    total++;
    if (res_ready !== 1'b1) $display("FAIL rstmid_recv: got rr=%b want 1", res_ready);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({a, b, in_valid, res_ready, busy, done, txn_count, err_count, first_err_idx} !==
        {32'h0, 32'h0, 4'b0000, 16'd0, 16'd0, 16'hFFFF})
      $display("FAIL rstmid_async: got a=%h b=%h flags=%b txn=%0d err=%0d fei=%h want 0 0 0000 0 0 ffff",
               a, b, {in_valid, res_ready, busy, done}, txn_count, err_count, first_err_idx);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(1'b0, 16'd2);
    run_txn(0, oa, ob, ok);
    total++;
    if (!ok || oa !== 32'h0000_0001 || ob !== 32'h0000_0002)
      $display("FAIL rstmid_rerun0: got ok=%0d a=%h b=%h want 00000001 00000002", ok, oa, ob);
    else passed++;
    run_txn(0, oa, ob, ok);
    total++;
    if (!ok || oa !== 32'h8020_0003 || ob !== 32'h0000_0001 || done !== 1'b1)
      $display("FAIL rstmid_rerun1: got ok=%0d a=%h b=%h done=%b want 80200003 00000001 1",
               ok, oa, ob, done);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_lfsr();
    test_backpressure();
    test_error_inject();
    test_zero_and_busy_start();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
